// File: rtl/instruction_c_xfer.sv
// Compressed control-transfer unit: decodes c.j/c.jal/c.beqz/c.bnez/c.jr/c.jalr,
// optionally reads rs1 for one cycle, then holds the result until downstream takes it.
module instruction_c_xfer #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iVALID,
  input  logic [15:0]     iIR,
  input  logic [PC_W-1:0] iPC,
  input  logic [XLEN-1:0] iRS1_DATA,
  input  logic            iREADY,
  input  logic            iFLUSH,
  output logic            oREADY,
  output logic [4:0]      oRS1,
  output logic            oVALID,
  output logic [PC_W-1:0] oPC,
  output logic            oTAKEN,
  output logic            oWE,
  output logic [4:0]      oRD,
  output logic [XLEN-1:0] oALU_OUT,
  output logic            oILLEGAL
);

  typedef enum logic [1:0] {IDLE, RDREG, HOLD} state_t;

  state_t          state, nextState;
  logic [15:0]     irReg, curIr;
  logic [PC_W-1:0] pcReg, curPc;
  logic            accept, needRead, loadRs1, loadResult;
  logic            isJ, isJal, isBeqz, isBnez, isJr, isJalr, isIllegal, jrForm;
  logic [4:0]      rs1Idx;
  logic [11:0]     cjOff;
  logic [8:0]      cbOff;
  logic [PC_W-1:0] cjSext, cbSext, pcPlus2, pcPlusCj, pcPlusCb;
  logic [XLEN-1:0] link;
  logic [PC_W-1:0] resPc;
  logic            resTaken, resWe, resIll, rs1Zero;

  assign oREADY = (state == IDLE);
  assign oVALID = (state == HOLD);
  assign accept = iVALID && oREADY;

  // In IDLE the incoming instruction is decoded directly; afterwards the latched copy is used.
  always_comb begin
    curIr = irReg;
    curPc = pcReg;
    if (state == IDLE) begin
      curIr = iIR;
      curPc = iPC;
    end
  end

  always_comb begin
    isJ    = (curIr[1:0] == 2'b01) && (curIr[15:13] == 3'b101);
    isJal  = (curIr[1:0] == 2'b01) && (curIr[15:13] == 3'b001) && (XLEN == 32);
    isBeqz = (curIr[1:0] == 2'b01) && (curIr[15:13] == 3'b110);
    isBnez = (curIr[1:0] == 2'b01) && (curIr[15:13] == 3'b111);
    jrForm = (curIr[1:0] == 2'b10) && (curIr[15:13] == 3'b100) &&
             (curIr[6:2] == 5'd0) && (curIr[11:7] != 5'd0);
    isJr   = jrForm && !curIr[12];
    isJalr = jrForm && curIr[12];
    isIllegal = !(isJ || isJal || isBeqz || isBnez || isJr || isJalr);
    needRead  = isJr || isJalr || isBeqz || isBnez;
    rs1Idx    = jrForm ? curIr[11:7] : {2'b01, curIr[9:7]};
  end

  // Offsets are sign-extended (or truncated) straight to PC_W so all PC math wraps mod 2^PC_W.
  always_comb begin
    cjOff = {curIr[12], curIr[8], curIr[10:9], curIr[6], curIr[7], curIr[2],
             curIr[11], curIr[5:3], 1'b0};
    cbOff = {curIr[12], curIr[6:5], curIr[2], curIr[11:10], curIr[4:3], 1'b0};
    for (int i = 0; i < PC_W; i++) begin
      cjSext[i] = cjOff[(i < 12) ? i : 11];
      cbSext[i] = cbOff[(i < 9) ? i : 8];
    end
  end

  assign pcPlus2  = curPc + PC_W'(2);
  assign pcPlusCj = curPc + cjSext;
  assign pcPlusCb = curPc + cbSext;
  assign rs1Zero  = (iRS1_DATA == '0);

  always_comb begin
    link = '0;
    link[PC_W-1:0] = pcPlus2;
  end

  always_comb begin
    resPc    = pcPlus2;
    resTaken = 1'b0;
    resWe    = 1'b0;
    resIll   = 1'b0;
    if (isJ || isJal) begin
      resPc    = pcPlusCj;
      resTaken = 1'b1;
      resWe    = isJal;
    end else if (isJr || isJalr) begin
      resPc    = {iRS1_DATA[PC_W-1:1], 1'b0};
      resTaken = 1'b1;
      resWe    = isJalr;
    end else if (isBeqz || isBnez) begin
      resTaken = isBeqz ? rs1Zero : !rs1Zero;
      resPc    = resTaken ? pcPlusCb : pcPlus2;
    end else begin
      resIll   = isIllegal;
    end
  end

  // Flush overrides every transition, including a same-cycle accept or iREADY.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = needRead ? RDREG : HOLD;
      RDREG:   nextState = HOLD;
      HOLD:    if (iREADY) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (iFLUSH) nextState = IDLE;
  end

  assign loadRs1    = !iFLUSH && (state == IDLE) && accept && needRead;
  assign loadResult = !iFLUSH && (((state == IDLE) && accept && !needRead) || (state == RDREG));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= nextState;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      irReg    <= '0;
      pcReg    <= '0;
      oRS1     <= '0;
      oPC      <= '0;
      oTAKEN   <= 1'b0;
      oWE      <= 1'b0;
      oRD      <= '0;
      oALU_OUT <= '0;
      oILLEGAL <= 1'b0;
    end else begin
      if (accept) begin
        irReg <= iIR;
        pcReg <= iPC;
      end
      if (loadRs1) oRS1 <= rs1Idx;
      if (loadResult) begin
        oPC      <= resPc;
        oTAKEN   <= resTaken;
        oWE      <= resWe;
        oRD      <= resWe ? 5'd1 : 5'd0;
        oALU_OUT <= resWe ? link : '0;
        oILLEGAL <= resIll;
      end
    end
  end

endmodule

// File: tb/tb_instruction_c_xfer.sv
// Scoreboard bench for instruction_c_xfer: expected results are queued when an
// instruction is issued and compared when the unit presents oVALID.
module tb_instruction_c_xfer;

  localparam int XLEN = 32;
  localparam int PC_W = 32;

  logic            iCLK = 1'b0;
  logic            iRST = 1'b0;
  logic            iVALID = 1'b0;
  logic [15:0]     iIR = '0;
  logic [PC_W-1:0] iPC = '0;
  logic [XLEN-1:0] iRS1_DATA = '0;
  logic            iREADY = 1'b0;
  logic            iFLUSH = 1'b0;
  logic            oREADY;
  logic [4:0]      oRS1;
  logic            oVALID;
  logic [PC_W-1:0] oPC;
  logic            oTAKEN;
  logic            oWE;
  logic [4:0]      oRD;
  logic [XLEN-1:0] oALU_OUT;
  logic            oILLEGAL;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int passes = 0;

  instruction_c_xfer #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .iIR(iIR), .iPC(iPC),
    .iRS1_DATA(iRS1_DATA), .iREADY(iREADY), .iFLUSH(iFLUSH),
    .oREADY(oREADY), .oRS1(oRS1), .oVALID(oVALID), .oPC(oPC), .oTAKEN(oTAKEN),
    .oWE(oWE), .oRD(oRD), .oALU_OUT(oALU_OUT), .oILLEGAL(oILLEGAL)
  );

  always #5 iCLK = ~iCLK;

  task automatic sendInstr(input logic [15:0] ir, input logic [31:0] pc);
    iVALID = 1'b1;
    iIR    = ir;
    iPC    = pc;
    @(posedge iCLK); #1;
    iVALID = 1'b0;
  endtask

  task automatic releaseHold();
    iREADY = 1'b1;
    @(posedge iCLK); #1;
    iREADY = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    @(posedge iCLK); #1;
    checks++;
    if ({oVALID, oTAKEN, oWE, oILLEGAL, oPC, oALU_OUT, oRD, oRS1} !== '0 || oREADY !== 1'b1)
      $display("[TB] FAIL reset_state: got %h ready=%b expected all zero ready=1",
               {oVALID, oTAKEN, oWE, oILLEGAL, oPC, oALU_OUT, oRD, oRS1}, oREADY);
    else passes++;
    iRST = 1'b0;
    @(posedge iCLK); #1;
    checks++;
    if (oREADY !== 1'b1) $display("[TB] FAIL reset_release_ready: got %b expected 1", oREADY);
    else passes++;
  endtask

  task automatic test_cj();
    sb.push_back({32'h104, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0});
    sendInstr(16'hA011, 32'h100);
    e = sb.pop_front();
    checks++;
    if ({oVALID, oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL} !== {1'b1, e})
      $display("[TB] FAIL cj_result: got %h expected %h",
               {oVALID, oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL}, {1'b1, e});
    else passes++;
    releaseHold();
    checks++;
    if ({oVALID, oREADY} !== 2'b01) $display("[TB] FAIL cj_release: got valid,ready=%b expected 01", {oVALID, oREADY});
    else passes++;
  endtask

  task automatic test_jal_hold();
    sb.push_back({32'h1FE, 1'b1, 1'b1, 5'd1, 32'h202, 1'b0});
    sendInstr(16'h3FFD, 32'h200);
    e = sb.pop_front();
    iIR = 16'hA011;
    iPC = 32'h999;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({oVALID, oREADY, oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL} !== {2'b10, e})
        $display("[TB] FAIL jal_hold_cycle%0d: got %h expected %h", c,
                 {oVALID, oREADY, oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL}, {2'b10, e});
      else passes++;
      @(posedge iCLK); #1;
    end
    releaseHold();
    checks++;
    if (oVALID !== 1'b0) $display("[TB] FAIL jal_release: oVALID got %b expected 0", oVALID);
    else passes++;
  endtask

  task automatic test_beqz();
    logic [31:0] data [2] = '{32'd0, 32'd5};
    exp_t        exps [2] = '{{32'h48, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0},
                              {32'h42, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0}};
    for (int k = 0; k < 2; k++) begin
      sb.push_back(exps[k]);
      sendInstr(16'hC401, 32'h40);
      checks++;
      if ({oRS1, oVALID, oREADY} !== {5'd8, 2'b00})
        $display("[TB] FAIL beqz_rdreg%0d: got rs1=%0d valid=%b ready=%b expected rs1=8 valid=0 ready=0",
                 k, oRS1, oVALID, oREADY);
      else passes++;
      iRS1_DATA = data[k];
      @(posedge iCLK); #1;
      iRS1_DATA = 32'hDEAD_BEEF;
      e = sb.pop_front();
      checks++;
      if ({oVALID, oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL} !== {1'b1, e})
        $display("[TB] FAIL beqz_result%0d: got %h expected %h", k,
                 {oVALID, oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL}, {1'b1, e});
      else passes++;
      releaseHold();
    end
  endtask

  task automatic test_jalr_and_illegal_jr();
    sb.push_back({32'h1234, 1'b1, 1'b1, 5'd1, 32'h302, 1'b0});
    sendInstr(16'h9282, 32'h300);
    checks++;
    if (oRS1 !== 5'd5) $display("[TB] FAIL jalr_rs1: got %0d expected 5", oRS1);
    else passes++;
    iRS1_DATA = 32'h1235;
    @(posedge iCLK); #1;
    e = sb.pop_front();
    checks++;
    if ({oVALID, oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL} !== {1'b1, e})
      $display("[TB] FAIL jalr_result: got %h expected %h",
               {oVALID, oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL}, {1'b1, e});
    else passes++;
    releaseHold();
    sb.push_back({32'h302, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1});
    sendInstr(16'h8002, 32'h300);
    e = sb.pop_front();
    checks++;
    if ({oVALID, oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL} !== {1'b1, e})
      $display("[TB] FAIL jr_x0_illegal: got %h expected %h",
               {oVALID, oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL}, {1'b1, e});
    else passes++;
    releaseHold();
  endtask

  task automatic test_wrap_and_illegal();
    logic [15:0] irs  [6] = '{16'hA011, 16'h3FFD, 16'h0000, 16'h0000, 16'h9286, 16'hFFFF};
    logic [31:0] pcs  [6] = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFE, 32'h10, 32'h20, 32'h30};
    exp_t        exps [6] = '{{32'h2,         1'b1, 1'b0, 5'd0, 32'd0, 1'b0},
                              {32'hFFFF_FFFE, 1'b1, 1'b1, 5'd1, 32'd2, 1'b0},
                              {32'h0,         1'b0, 1'b0, 5'd0, 32'd0, 1'b1},
                              {32'h12,        1'b0, 1'b0, 5'd0, 32'd0, 1'b1},
                              {32'h22,        1'b0, 1'b0, 5'd0, 32'd0, 1'b1},
                              {32'h32,        1'b0, 1'b0, 5'd0, 32'd0, 1'b1}};
    for (int k = 0; k < 6; k++) begin
      sb.push_back(exps[k]);
      sendInstr(irs[k], pcs[k]);
      e = sb.pop_front();
      checks++;
      if ({oVALID, oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL} !== {1'b1, e})
        $display("[TB] FAIL wrap_illegal%0d ir=%h: got %h expected %h", k, irs[k],
                 {oVALID, oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL}, {1'b1, e});
      else passes++;
      releaseHold();
    end
  endtask

  task automatic test_flush();
    sendInstr(16'hC401, 32'h40);
    iFLUSH = 1'b1;
    @(posedge iCLK); #1;
    iFLUSH = 1'b0;
    checks++;
    if ({oVALID, oREADY} !== 2'b01) $display("[TB] FAIL flush_rdreg: got valid,ready=%b expected 01", {oVALID, oREADY});
    else passes++;
    // A flush coinciding with an accept must leave the read index untouched.
    iVALID = 1'b1; iIR = 16'hC481; iPC = 32'h50; iFLUSH = 1'b1;
    @(posedge iCLK); #1;
    iVALID = 1'b0; iFLUSH = 1'b0;
    checks++;
    if ({oVALID, oREADY, oRS1} !== {2'b01, 5'd8})
      $display("[TB] FAIL flush_accept: got valid,ready,rs1=%b,%b,%0d expected 0,1,8", oVALID, oREADY, oRS1);
    else passes++;
    sendInstr(16'hA011, 32'h100);
    iFLUSH = 1'b1; iREADY = 1'b1;
    @(posedge iCLK); #1;
    iFLUSH = 1'b0; iREADY = 1'b0;
    checks++;
    if ({oVALID, oREADY} !== 2'b01) $display("[TB] FAIL flush_hold: got valid,ready=%b expected 01", {oVALID, oREADY});
    else passes++;
    sb.push_back({32'h0A4, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0});
    sendInstr(16'hA011, 32'hA0);
    e = sb.pop_front();
    checks++;
    if ({oVALID, oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL} !== {1'b1, e})
      $display("[TB] FAIL after_flush: got %h expected %h",
               {oVALID, oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL}, {1'b1, e});
    else passes++;
    releaseHold();
  endtask

  task automatic test_reset_mid_hold();
    sendInstr(16'h3FFD, 32'h200);
    #2;
    iRST = 1'b1;
    #1;
    checks++;
    if ({oVALID, oTAKEN, oWE, oILLEGAL, oPC, oALU_OUT, oRD, oRS1} !== '0)
      $display("[TB] FAIL reset_async: got %h expected all zero",
               {oVALID, oTAKEN, oWE, oILLEGAL, oPC, oALU_OUT, oRD, oRS1});
    else passes++;
    #2;
    iRST = 1'b0;
    @(posedge iCLK); #1;
    checks++;
    if ({oVALID, oREADY} !== 2'b01) $display("[TB] FAIL reset_mid_release: got valid,ready=%b expected 01", {oVALID, oREADY});
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] irs  [6] = '{16'hE401, 16'hE401, 16'h8282, 16'hBFFD, 16'hDFFD, 16'hA011};
    logic [31:0] pcs  [6] = '{32'h80, 32'h80, 32'h90, 32'h500, 32'h600, 32'h100};
    logic [31:0] data [6] = '{32'd5, 32'd0, 32'h777, 32'd0, 32'd0, 32'd0};
    exp_t        exps [6] = '{{32'h88,  1'b1, 1'b0, 5'd0, 32'd0, 1'b0},
                              {32'h82,  1'b0, 1'b0, 5'd0, 32'd0, 1'b0},
                              {32'h776, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0},
                              {32'h4FE, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0},
                              {32'h5FE, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0},
                              {32'h104, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0}};
    bit got;
    iREADY = 1'b1;
    for (int k = 0; k < 6; k++) begin
      iRS1_DATA = data[k];
      sb.push_back(exps[k]);
      sendInstr(irs[k], pcs[k]);
      got = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (oVALID === 1'b1) begin
          got = 1'b1;
          break;
        end
        @(posedge iCLK); #1;
      end
      e = sb.pop_front();
      checks++;
      if (!got)
        $display("[TB] FAIL b2b%0d_timeout: oVALID got 0 expected 1 within 4 cycles", k);
      else if ({oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL} !== e)
        $display("[TB] FAIL b2b%0d_result: got %h expected %h", k,
                 {oPC, oTAKEN, oWE, oRD, oALU_OUT, oILLEGAL}, e);
      else passes++;
      if (got) begin
        @(posedge iCLK); #1;
      end
    end
    iREADY = 1'b0;
    checks++;
    if (sb.size() != 0 || oREADY !== 1'b1)
      $display("[TB] FAIL b2b_drain: got queue=%0d ready=%b expected 0,1", sb.size(), oREADY);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_cj();
    test_jal_hold();
    test_beqz();
    test_jalr_and_illegal_jr();
    test_wrap_and_illegal();
    test_flush();
    test_reset_mid_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instruction_c_xfer.md
INSTRUCTION_C_XFER -- requirements
Module: instruction_c_xfer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width; legal values are 32 and 64.
REQ-002 SHALL have parameter PC_W, default 32, meaning PC width; legal range is 8..XLEN.
REQ-003 iCLK  in  1  single clock; all state changes on posedge.
REQ-004 iRST  in  1  asynchronous, active-high reset.
REQ-005 iVALID  in  1  upstream has a 16-bit instruction.
REQ-006 iIR  in  16  compressed instruction.
REQ-007 iPC  in  PC_W  address of iIR.
REQ-008 iRS1_DATA  in  XLEN  register-file read data, valid one cycle after oRS1 is presented.
REQ-009 iREADY  in  1  downstream accepts the result.
REQ-010 iFLUSH  in  1  synchronous pipeline kill.
REQ-011 oREADY  out  1  unit can accept an instruction.
REQ-012 oRS1  out  5  register-file read index.
REQ-013 oVALID  out  1  result valid.
REQ-014 oPC  out  PC_W  next PC.
REQ-015 oTAKEN  out  1  control transfer taken.
REQ-016 oWE  out  1  link write enable.
REQ-017 oRD  out  5  link destination register.
REQ-018 oALU_OUT  out  XLEN  link value.
REQ-019 oILLEGAL  out  1  encoding not handled.

Function
REQ-020 SHALL decode the following encodings:
- c.j: quadrant 01, funct3 101.
- c.jal: quadrant 01, funct3 001; XLEN==32 only, otherwise illegal.
- c.beqz: quadrant 01, funct3 110.
- c.bnez: quadrant 01, funct3 111.
- c.jr: quadrant 10, funct3 100, ir[12]=0, ir[6:2]=0.
- c.jalr: quadrant 10, funct3 100, ir[12]=1, ir[6:2]=0.
- c.jr/c.jalr with rs1=ir[11:7]=0 are illegal; every other encoding is illegal.
REQ-021 SHALL form the CJ offset as sign-extended {ir12,ir8,ir10:9,ir6,ir7,ir2,ir11,ir5:3,0}, 12 bits.
REQ-022 SHALL form the CB offset as sign-extended {ir12,ir6:5,ir2,ir11:10,ir4:3,0}, 9 bits; rs1' = {2'b01, ir[9:7]}.
REQ-023 SHALL implement FSM states IDLE, RDREG and HOLD; oREADY=1 only in IDLE; accept = iVALID && oREADY.
REQ-024 On accept, SHALL latch iIR and iPC, then:
- c.jr/c.jalr/c.beqz/c.bnez: go to RDREG and drive oRS1 from the latched field.
- all other instructions, including illegal ones: go to HOLD.
REQ-025 RDREG SHALL last exactly one cycle, sample iRS1_DATA at its end, and go to HOLD.
REQ-026 Latency from accept to oVALID SHALL be 1 cycle without register read and 2 cycles with register read.
REQ-027 In HOLD, oVALID=1 and all outputs SHALL stay stable until iREADY=1; on iREADY=1 go to IDLE and drop oVALID next cycle.
REQ-028 Results:
- Jumps: oTAKEN=1.
- c.j/c.jal: oPC = PC + offset.
- c.jr/c.jalr: oPC = rs1 data with bit0 cleared, truncated to PC_W.
- Branches: oTAKEN = (rs1==0) for beqz, (rs1!=0) for bnez; oPC = taken ? PC+offset : PC+2.
REQ-029 c.jal/c.jalr SHALL set oWE=1, oRD=1 and oALU_OUT = PC+2 zero-extended; every other instruction SHALL set oWE=0, oRD=0, oALU_OUT=0.
REQ-030 Illegal instructions SHALL produce oVALID with oILLEGAL=1, oTAKEN=0, oWE=0 and oPC=PC+2.
REQ-031 All PC arithmetic SHALL be modulo 2^PC_W; wrap from all-ones to 0 SHALL be silent.
REQ-032 iFLUSH=1 SHALL force IDLE on the next edge from any state, discarding the pending instruction; oVALID=0 next cycle; flush wins over a simultaneous accept or iREADY.
REQ-033 oRS1 SHALL hold its last value outside RDREG.

Reset
REQ-034 iRST=1 SHALL immediately force IDLE and drive oVALID, oTAKEN, oWE and oILLEGAL to 0, and oPC, oALU_OUT, oRD and oRS1 to 0, regardless of clock.
REQ-035 After iRST deasserts, oREADY SHALL be 1 at the first edge.

Verification
REQ-036 c.j 0xA011, PC=0x100 -> one cycle later oVALID=1, oPC=0x104, oTAKEN=1, oWE=0.
REQ-037 c.jal 0x3FFD, PC=0x200 -> oPC=0x1FE, oWE=1, oRD=1, oALU_OUT=0x202.
REQ-038 c.beqz 0xC401, PC=0x40:
- oRS1=8 in RDREG; iRS1_DATA=0 -> oPC=0x48, oTAKEN=1, oVALID two cycles after accept.
- iRS1_DATA=5 -> oPC=0x42, oTAKEN=0.
REQ-039 c.jalr 0x9282, PC=0x300, iRS1_DATA=0x1235 -> oRS1=5, oPC=0x1234, oALU_OUT=0x302; c.jr x0 0x8002 -> oILLEGAL=1, oPC=0x302.
REQ-040 Handshake, flush and reset:
- iREADY low 3 cycles in HOLD -> outputs stable, oREADY=0.
- iFLUSH during RDREG -> no oVALID, oREADY=1 next cycle.
- iRST asserted mid-HOLD -> oVALID=0 before the next edge.
